// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative radix-2 divider: FSM states, div_op
// bit positions and the default operand width.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  localparam int DIV_OP_SGN  = 0;
  localparam int DIV_OP_USGN = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle for iter_divider, including the flush control.
interface iter_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic               flush;
  logic [1:0]         div_op;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               div_in_valid;
  logic               div_in_ready;
  logic [2*WIDTH-1:0] div_result;
  logic               div_out_valid;
  logic               div_out_ready;

  modport master (
    output flush, div_op, dividend, divisor, div_in_valid, div_out_ready,
    input  div_in_ready, div_result, div_out_valid
  );

  modport slave (
    input  flush, div_op, dividend, divisor, div_in_valid, div_out_ready,
    output div_in_ready, div_result, div_out_valid
  );

endinterface

// File: rtl/iter_divider_step.sv
// One restoring division iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dmag,
  input  logic             dbit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, dbit};
  assign diff    = shifted - {1'b0, dmag};
  // Partial remainder stays below dmag, so a borrow lands exactly in bit WIDTH.
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// Iterative signed/unsigned divider: one setup cycle, WIDTH restoring steps,
// a sign-fix cycle, then the result is held in DONE until consumed.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  iter_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          in_ready;

  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;
  logic                    sgn_q;
  logic [WIDTH-1:0]        rem;
  logic [WIDTH-1:0]        shreg;
  logic [WIDTH-1:0]        dmag;
  logic [WIDTH-1:0]        step_rem;
  logic                    step_q;
  logic [2*WIDTH-1:0]      result_q;
  logic [2*WIDTH-1:0]      result_fix;
  logic                    neg_q;
  logic                    neg_r;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                               input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                            input logic sgn);
    return neg_if(v, sgn & v[WIDTH-1]);
  endfunction

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) || ((state == DONE) && bus.div_out_ready);
    accept    = bus.div_in_valid && in_ready && !bus.flush;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (cnt == CW'(WIDTH)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.div_out_ready) state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= ((state == CALC) && (state_nxt == CALC)) ? cnt + CW'(1) : '0;
    end
  end

  assign bus.div_in_ready  = in_ready;
  assign bus.div_out_valid = (state == DONE);
  assign bus.div_result    = result_q;

  // ---- stage: operand capture and iteration (cnt 0 loads magnitudes) ----
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dmag    (dmag),
    .dbit    (shreg[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= bus.dividend;
      b_q   <= bus.divisor;
      sgn_q <= bus.div_op[DIV_OP_SGN] & ~bus.div_op[DIV_OP_USGN];
    end
    if (state == CALC) begin
      if (cnt == '0) begin
        rem   <= '0;
        shreg <= mag(a_q, sgn_q);
        dmag  <= mag(b_q, sgn_q);
      end else begin
        rem   <= step_rem;
        shreg <= {shreg[WIDTH-2:0], step_q};
      end
    end
  end

  // ---- stage: sign correction and result register ----
  assign neg_q = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign neg_r = sgn_q & a_q[WIDTH-1];
  // Zero divisor bypasses the datapath so the dividend is returned untouched.
  assign result_fix = (b_q == '0) ? {a_q, {WIDTH{1'b1}}}
                                  : {neg_if(rem, neg_r), neg_if(shreg, neg_q)};

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if ((state == FIX) && !bus.flush) begin
      result_q <= result_fix;
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed-vector bench for iter_divider (WIDTH=32): results, latency,
// flush, back-pressure and reset behaviour.
module tb_iter_divider;

  localparam int W = 32;
  localparam logic [1:0] OP_S = 2'b01;
  localparam logic [1:0] OP_U = 2'b10;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  iter_divider_if #(.WIDTH(W)) bus ();

  iter_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request and return just after its acceptance edge.
  task automatic launch(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    bus.div_op       = op;
    bus.dividend     = a;
    bus.divisor      = b;
    bus.div_in_valid = 1'b1;
    n = 0;
    while (bus.div_in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({tag, "_ready_timeout"}, 64'(n), 64'd0);
    @(posedge clk);
    #1;
    bus.div_in_valid = 1'b0;
  endtask

  // Count edges from the acceptance edge to div_out_valid, check, optionally drain.
  task automatic wait_result(input string tag, input logic [63:0] exp, input bit drain);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.div_out_valid === 1'b1) break;
    end
    bus.div_in_valid = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'(W + 2));
    chk({tag, "_result"}, bus.div_result, exp);
    if (drain) begin
      @(negedge clk);
      bus.div_out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.div_out_ready = 1'b0;
      chk({tag, "_drained"}, 64'(bus.div_out_valid), 64'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input bit noise);
    launch(tag, op, a, b);
    if (noise) begin
      // Stray requests while busy must be ignored.
      bus.div_in_valid = 1'b1;
      bus.div_op       = OP_U;
      bus.dividend     = 32'h1234_5678;
      bus.divisor      = 32'h0000_0003;
      @(negedge clk);
      chk({tag, "_busy_ready"}, 64'(bus.div_in_ready), 64'd0);
      @(posedge clk);
      #1;
      wait_result_offset(tag, exp);
    end else begin
      wait_result(tag, exp, 1'b1);
    end
  endtask

  // Same as wait_result but one edge has already elapsed since acceptance.
  task automatic wait_result_offset(input string tag, input logic [63:0] exp);
    int n;
    n = 1;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.div_out_valid === 1'b1) break;
    end
    bus.div_in_valid = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'(W + 2));
    chk({tag, "_result"}, bus.div_result, exp);
    @(negedge clk);
    bus.div_out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.div_out_ready = 1'b0;
    chk({tag, "_drained"}, 64'(bus.div_out_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] held;
    bit          seen;
    checks   = 0;
    failures = 0;
    rst               = 1'b1;
    bus.flush         = 1'b0;
    bus.div_op        = OP_U;
    bus.dividend      = '0;
    bus.divisor       = '0;
    bus.div_in_valid  = 1'b0;
    bus.div_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 64'(bus.div_in_ready), 64'd1);
    chk("rst_valid", 64'(bus.div_out_valid), 64'd0);
    chk("rst_result", bus.div_result, 64'd0);

    run_op("u100_7",   OP_U, 32'd100,       32'd7,        {32'h0000_0002, 32'h0000_000E}, 1'b0);
    run_op("s_m7_2",   OP_S, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_op("s_7_m2",   OP_S, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b1);
    run_op("s5_0",     OP_S, 32'd5,         32'd0,        {32'h0000_0005, 32'hFFFF_FFFF}, 1'b0);
    run_op("s_minneg", OP_S, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b0);
    run_op("u_max_0",  OP_U, 32'hFFFF_FFFF, 32'd0,        {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1'b0);
    run_op("u_max_16", OP_U, 32'hFFFF_FFFF, 32'h10,       {32'h0000_000F, 32'h0FFF_FFFF}, 1'b0);
    run_op("s_m100_m7", OP_S, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}, 1'b0);
    run_op("u_big",    OP_U, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 1'b0);

    // Flush mid-CALC together with a new request.
    launch("flush", OP_U, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush        = 1'b1;
    bus.div_in_valid = 1'b1;
    bus.dividend     = 32'd50;
    bus.divisor      = 32'd5;
    @(posedge clk);
    #1;
    bus.flush        = 1'b0;
    bus.div_in_valid = 1'b0;
    chk("flush_ready", 64'(bus.div_in_ready), 64'd1);
    chk("flush_valid", 64'(bus.div_out_valid), 64'd0);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (bus.div_out_valid !== 1'b0) seen = 1'b1;
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    run_op("u9_3", OP_U, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

    // Back-pressure in DONE, then back-to-back acceptance.
    launch("hold", OP_U, 32'd100, 32'd7);
    wait_result("hold", {32'd2, 32'd14}, 1'b0);
    held = bus.div_result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", bus.div_result, held);
      chk("hold_ready", 64'(bus.div_in_ready), 64'd0);
    end
    @(negedge clk);
    bus.div_out_ready = 1'b1;
    bus.div_in_valid  = 1'b1;
    bus.div_op        = OP_U;
    bus.dividend      = 32'd77;
    bus.divisor       = 32'd10;
    #1;
    chk("b2b_ready", 64'(bus.div_in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.div_out_ready = 1'b0;
    bus.div_in_valid  = 1'b0;
    chk("b2b_valid_low", 64'(bus.div_out_valid), 64'd0);
    wait_result("b2b", {32'd7, 32'd7}, 1'b1);

    // Reset mid-CALC.
    launch("rstmid", OP_U, 32'd500, 32'd9);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid_valid", 64'(bus.div_out_valid), 64'd0);
    chk("rstmid_result", bus.div_result, 64'd0);
    chk("rstmid_ready", 64'(bus.div_in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.div_out_valid !== 1'b0) seen = 1'b1;
    end
    chk("rstmid_no_result", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
